// File: rtl/lfst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfst_pkg
// Purpose  : Shared defaults, types and the ROB-relative age helper for the
//            Last Fetched Store Table.
// Revision : 1.0 - initial parametrised multi-width release
// ============================================================================
package lfst_pkg;

  localparam int LFST_SSID_W = 7;
  localparam int LFST_INUM_W = 7;
  localparam int LFST_RN_W   = 4;
  localparam int LFST_RT_W   = 2;
  localparam int LFST_NSETS  = 2 ** LFST_SSID_W;

  typedef logic [LFST_SSID_W-1:0] ssid_t;
  typedef logic [LFST_INUM_W-1:0] inum_t;

  // Distance of an inum from the ROB head. Inums are a circular pointer, so
  // the modular subtraction turns "older/younger" into a plain unsigned compare.
  function automatic inum_t inum_age(input inum_t x, input inum_t head);
    return x - head;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfst_rd_port.sv
`default_nettype none
// ============================================================================
// Module   : lfst_rd_port
// Purpose  : One rename-slot lookup into the LFST with intra-bundle bypass
//            from older slots (0..K-1). Purely combinational.
// Revision : 1.0 - initial parametrised multi-width release
// ============================================================================
module lfst_rd_port
  import lfst_pkg::*;
#(
  parameter int SSID_W = LFST_SSID_W,
  parameter int INUM_W = LFST_INUM_W,
  parameter int RN_W   = LFST_RN_W,
  parameter int NSETS  = 2 ** SSID_W,
  parameter int K      = 0
) (
  input  logic [NSETS-1:0]        tbl_vld_i,
  input  logic [NSETS*INUM_W-1:0] tbl_inum_i,
  input  logic [SSID_W-1:0]       rd_ssid_i,
  input  logic                    rd_ssid_vld_i,
  input  logic [RN_W-1:0]         wr_en_i,
  input  logic [RN_W*SSID_W-1:0]  wr_idx_i,
  input  logic [RN_W*INUM_W-1:0]  wr_inum_i,
  output logic [INUM_W-1:0]       lfs_o,
  output logic                    lfs_vld_o
);

  // Slots at or after K never feed this port; fold them into a sink so every
  // instance sees the same full-width bundle without unused-bit noise.
  logic unused_wr_bits;
  assign unused_wr_bits = ^{wr_en_i, wr_idx_i, wr_inum_i};

  // Table lookup, then let older same-set stores override; ascending order
  // means the youngest older store is the one left standing.
  always_comb begin
    lfs_o     = tbl_inum_i[rd_ssid_i*INUM_W +: INUM_W];
    lfs_vld_o = tbl_vld_i[rd_ssid_i] & rd_ssid_vld_i;
    for (int j = 0; j < RN_W; j++) begin
      if ((j < K) && wr_en_i[j] && (wr_idx_i[j*SSID_W +: SSID_W] == rd_ssid_i)) begin
        lfs_o     = wr_inum_i[j*INUM_W +: INUM_W];
        lfs_vld_o = rd_ssid_vld_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lfst_mw.sv
`default_nettype none
// ============================================================================
// Module   : lfst_mw
// Purpose  : Multi-width Last Fetched Store Table. Holds, per store set, the
//            inum of the most recently renamed store; supports flush, age-based
//            partial squash, retire invalidation and a valid-entry count.
// Revision : 1.0 - initial parametrised multi-width release
// ============================================================================
module lfst_mw
  import lfst_pkg::*;
#(
  parameter int SSID_W = LFST_SSID_W,
  parameter int INUM_W = LFST_INUM_W,
  parameter int RN_W   = LFST_RN_W,
  parameter int RT_W   = LFST_RT_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush_i,
  input  logic                   squash_i,
  input  logic [INUM_W-1:0]      squash_inum_i,
  input  logic [INUM_W-1:0]      head_inum_i,
  input  logic [RN_W*SSID_W-1:0] rd_ssid_i,
  input  logic [RN_W-1:0]        rd_ssid_vld_i,
  input  logic [RN_W-1:0]        wr_en_i,
  input  logic [RN_W*SSID_W-1:0] wr_idx_i,
  input  logic [RN_W*INUM_W-1:0] wr_inum_i,
  input  logic [RT_W-1:0]        inv_en_i,
  input  logic [RT_W*INUM_W-1:0] inv_inum_i,
  output logic [RN_W*INUM_W-1:0] lfs_o,
  output logic [RN_W-1:0]        lfs_vld_o,
  output logic [SSID_W:0]        vld_cnt_o
);

  localparam int NSETS = 2 ** SSID_W;

  logic [NSETS-1:0]        vld_q, vld_d;
  logic [INUM_W-1:0]       inum_q [NSETS];
  logic [INUM_W-1:0]       inum_d [NSETS];
  logic [SSID_W:0]         cnt_q, cnt_d;
  logic [NSETS*INUM_W-1:0] w_tbl_inum;
  logic [INUM_W-1:0]       w_ent_age [NSETS];
  logic [INUM_W-1:0]       w_sq_age;
  logic [RN_W-1:0]         w_port_vld;

  // Flatten the inum array so each read port can index it directly.
  for (genvar e = 0; e < NSETS; e++) begin : g_flat
    assign w_tbl_inum[e*INUM_W +: INUM_W] = inum_q[e];
  end

  // ROB-relative ages for the squash compare; the package helper is sized for
  // the default inum width, other widths use the same modular subtraction.
  if (INUM_W == LFST_INUM_W) begin : g_age_pkg
    assign w_sq_age = inum_age(squash_inum_i, head_inum_i);
    for (genvar e = 0; e < NSETS; e++) begin : g_ent
      assign w_ent_age[e] = inum_age(inum_q[e], head_inum_i);
    end
  end else begin : g_age_gen
    assign w_sq_age = squash_inum_i - head_inum_i;
    for (genvar e = 0; e < NSETS; e++) begin : g_ent
      assign w_ent_age[e] = inum_q[e] - head_inum_i;
    end
  end

  // Next table state: flush > squash > write > invalidate. Clears are applied
  // first so a same-cycle write to the entry overrides them.
  always_comb begin
    logic [SSID_W-1:0] idx;
    idx   = '0;
    vld_d = vld_q;
    for (int e = 0; e < NSETS; e++) begin
      inum_d[e] = inum_q[e];
    end
    if (flush_i) begin
      vld_d = '0;
    end else begin
      for (int e = 0; e < NSETS; e++) begin
        if (squash_i && vld_q[e] && (w_ent_age[e] >= w_sq_age)) begin
          vld_d[e] = 1'b0;
        end
        for (int r = 0; r < RT_W; r++) begin
          if (inv_en_i[r] && (inv_inum_i[r*INUM_W +: INUM_W] == inum_q[e])) begin
            vld_d[e] = 1'b0;
          end
        end
      end
      // Wrong-path writes are dropped during a squash; ascending slot order
      // leaves the youngest duplicate in place.
      if (!squash_i) begin
        for (int k = 0; k < RN_W; k++) begin
          if (wr_en_i[k]) begin
            idx         = wr_idx_i[k*SSID_W +: SSID_W];
            vld_d[idx]  = 1'b1;
            inum_d[idx] = wr_inum_i[k*INUM_W +: INUM_W];
          end
        end
      end
    end
  end

  // Population count of the next valid vector, registered alongside it.
  always_comb begin
    cnt_d = '0;
    for (int e = 0; e < NSETS; e++) begin
      cnt_d = cnt_d + {{SSID_W{1'b0}}, vld_d[e]};
    end
  end

  // Table and counter registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int e = 0; e < NSETS; e++) begin
        inum_q[e] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int e = 0; e < NSETS; e++) begin
        inum_q[e] <= inum_d[e];
      end
    end
  end

  assign vld_cnt_o = cnt_q;

  // One lookup port per rename slot; slot K only sees bypass from slots < K.
  for (genvar k = 0; k < RN_W; k++) begin : g_rd
    lfst_rd_port #(
      .SSID_W (SSID_W),
      .INUM_W (INUM_W),
      .RN_W   (RN_W),
      .NSETS  (NSETS),
      .K      (k)
    ) u_rd_port (
      .tbl_vld_i     (vld_q),
      .tbl_inum_i    (w_tbl_inum),
      .rd_ssid_i     (rd_ssid_i[k*SSID_W +: SSID_W]),
      .rd_ssid_vld_i (rd_ssid_vld_i[k]),
      .wr_en_i       (wr_en_i),
      .wr_idx_i      (wr_idx_i),
      .wr_inum_i     (wr_inum_i),
      .lfs_o         (lfs_o[k*INUM_W +: INUM_W]),
      .lfs_vld_o     (w_port_vld[k])
    );
    // Bypassed writes are not trusted while reset is held.
    assign lfs_vld_o[k] = w_port_vld[k] & reset_n;
  end

endmodule
`default_nettype wire

// File: tb/tb_lfst_mw.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfst_mw
// Purpose  : Directed self-checking bench for lfst_mw (default 128x7, 4-wide).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfst_mw;

  logic        clock;
  logic        reset_n;
  logic        flush_i;
  logic        squash_i;
  logic [6:0]  squash_inum_i;
  logic [6:0]  head_inum_i;
  logic [27:0] rd_ssid_i;
  logic [3:0]  rd_ssid_vld_i;
  logic [3:0]  wr_en_i;
  logic [27:0] wr_idx_i;
  logic [27:0] wr_inum_i;
  logic [1:0]  inv_en_i;
  logic [13:0] inv_inum_i;
  logic [27:0] lfs_o;
  logic [3:0]  lfs_vld_o;
  logic [7:0]  vld_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  lfst_mw u_dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .flush_i       (flush_i),
    .squash_i      (squash_i),
    .squash_inum_i (squash_inum_i),
    .head_inum_i   (head_inum_i),
    .rd_ssid_i     (rd_ssid_i),
    .rd_ssid_vld_i (rd_ssid_vld_i),
    .wr_en_i       (wr_en_i),
    .wr_idx_i      (wr_idx_i),
    .wr_inum_i     (wr_inum_i),
    .inv_en_i      (inv_en_i),
    .inv_inum_i    (inv_inum_i),
    .lfs_o         (lfs_o),
    .lfs_vld_o     (lfs_vld_o),
    .vld_cnt_o     (vld_cnt_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    flush_i       = 1'b0;
    squash_i      = 1'b0;
    squash_inum_i = '0;
    rd_ssid_i     = '0;
    rd_ssid_vld_i = '0;
    wr_en_i       = '0;
    wr_idx_i      = '0;
    wr_inum_i     = '0;
    inv_en_i      = '0;
    inv_inum_i    = '0;
  endtask

  task automatic set_rd(input int k, input logic [6:0] ssid);
    rd_ssid_i[k*7 +: 7] = ssid;
    rd_ssid_vld_i[k]    = 1'b1;
  endtask

  task automatic set_wr(input int k, input logic [6:0] ssid, input logic [6:0] inum);
    wr_en_i[k]          = 1'b1;
    wr_idx_i[k*7 +: 7]  = ssid;
    wr_inum_i[k*7 +: 7] = inum;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    head_inum_i = '0;
    clear_inputs();
    set_rd(0, 7'd5);
    set_wr(0, 7'd5, 7'h44);
    set_rd(1, 7'd5);
    #2;
    n_vec++;
    if (lfs_vld_o !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_lfs_vld got=%b exp=%b", lfs_vld_o, 4'b0000);
    end
    n_vec++;
    if (vld_cnt_o !== 8'd0) begin
      n_err++;
      $display("FAIL reset_cnt got=%0d exp=0", vld_cnt_o);
    end
    n_vec++;
    if (lfs_o[6:0] !== 7'h00) begin
      n_err++;
      $display("FAIL reset_lfs0 got=%h exp=00", lfs_o[6:0]);
    end
    tick();
    tick();
    clear_inputs();
    reset_n = 1'b1;
    tick();
    set_rd(0, 7'd5);
    #1;
    n_vec++;
    if (lfs_vld_o[0] !== 1'b0 || vld_cnt_o !== 8'd0) begin
      n_err++;
      $display("FAIL post_reset_read got vld=%b cnt=%0d exp vld=0 cnt=0", lfs_vld_o[0], vld_cnt_o);
    end
  endtask

  task automatic test_write_read();
    clear_inputs();
    set_wr(1, 7'd9, 7'h12);
    tick();
    clear_inputs();
    set_rd(0, 7'd9);
    #1;
    n_vec++;
    if (lfs_o[6:0] !== 7'h12 || lfs_vld_o[0] !== 1'b1) begin
      n_err++;
      $display("FAIL write_read got lfs=%h vld=%b exp lfs=12 vld=1", lfs_o[6:0], lfs_vld_o[0]);
    end
    n_vec++;
    if (vld_cnt_o !== 8'd1) begin
      n_err++;
      $display("FAIL write_read_cnt got=%0d exp=1", vld_cnt_o);
    end
  endtask

  task automatic test_bundle();
    clear_inputs();
    set_wr(0, 7'd3, 7'h20);
    set_wr(2, 7'd3, 7'h22);
    set_rd(0, 7'd3);
    set_rd(1, 7'd3);
    set_rd(2, 7'd3);
    set_rd(3, 7'd3);
    #1;
    n_vec++;
    if (lfs_vld_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL no_self_bypass0 got vld=%b exp=0", lfs_vld_o[0]);
    end
    n_vec++;
    if (lfs_o[13:7] !== 7'h20 || lfs_vld_o[1] !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_slot1 got lfs=%h vld=%b exp lfs=20 vld=1", lfs_o[13:7], lfs_vld_o[1]);
    end
    n_vec++;
    if (lfs_o[20:14] !== 7'h20 || lfs_vld_o[2] !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_slot2 got lfs=%h vld=%b exp lfs=20 vld=1", lfs_o[20:14], lfs_vld_o[2]);
    end
    n_vec++;
    if (lfs_o[27:21] !== 7'h22 || lfs_vld_o[3] !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_slot3 got lfs=%h vld=%b exp lfs=22 vld=1", lfs_o[27:21], lfs_vld_o[3]);
    end
    tick();
    clear_inputs();
    set_rd(0, 7'd3);
    #1;
    n_vec++;
    if (lfs_o[6:0] !== 7'h22 || lfs_vld_o[0] !== 1'b1 || vld_cnt_o !== 8'd2) begin
      n_err++;
      $display("FAIL dup_write_youngest got lfs=%h vld=%b cnt=%0d exp lfs=22 vld=1 cnt=2",
               lfs_o[6:0], lfs_vld_o[0], vld_cnt_o);
    end
  endtask

  task automatic test_squash();
    clear_inputs();
    flush_i = 1'b1;
    tick();
    clear_inputs();
    #1;
    n_vec++;
    if (vld_cnt_o !== 8'd0) begin
      n_err++;
      $display("FAIL flush_cnt got=%0d exp=0", vld_cnt_o);
    end
    head_inum_i = 7'h7C;
    set_wr(0, 7'd10, 7'h7E);
    set_wr(1, 7'd11, 7'h02);
    set_wr(2, 7'd12, 7'h05);
    tick();
    clear_inputs();
    n_vec++;
    if (vld_cnt_o !== 8'd3) begin
      n_err++;
      $display("FAIL squash_setup_cnt got=%0d exp=3", vld_cnt_o);
    end
    squash_i      = 1'b1;
    squash_inum_i = 7'h02;
    set_wr(0, 7'd20, 7'h7D);
    tick();
    clear_inputs();
    set_rd(0, 7'd10);
    set_rd(1, 7'd11);
    set_rd(2, 7'd12);
    set_rd(3, 7'd20);
    #1;
    n_vec++;
    if (vld_cnt_o !== 8'd1) begin
      n_err++;
      $display("FAIL squash_wrap_cnt got=%0d exp=1", vld_cnt_o);
    end
    n_vec++;
    if (lfs_vld_o !== 4'b0001 || lfs_o[6:0] !== 7'h7E) begin
      n_err++;
      $display("FAIL squash_wrap_entries got vld=%b lfs0=%h exp vld=0001 lfs0=7e", lfs_vld_o, lfs_o[6:0]);
    end
    squash_i      = 1'b1;
    squash_inum_i = 7'h7C;
    tick();
    clear_inputs();
    n_vec++;
    if (vld_cnt_o !== 8'd0) begin
      n_err++;
      $display("FAIL squash_age0_cnt got=%0d exp=0", vld_cnt_o);
    end
  endtask

  task automatic test_inv_write();
    clear_inputs();
    head_inum_i = 7'h00;
    set_wr(0, 7'd40, 7'h30);
    tick();
    clear_inputs();
    inv_en_i[0]     = 1'b1;
    inv_inum_i[6:0] = 7'h30;
    set_wr(3, 7'd40, 7'h31);
    tick();
    clear_inputs();
    set_rd(2, 7'd40);
    #1;
    n_vec++;
    if (lfs_o[20:14] !== 7'h31 || lfs_vld_o[2] !== 1'b1 || vld_cnt_o !== 8'd1) begin
      n_err++;
      $display("FAIL write_beats_inv got lfs=%h vld=%b cnt=%0d exp lfs=31 vld=1 cnt=1",
               lfs_o[20:14], lfs_vld_o[2], vld_cnt_o);
    end
    inv_en_i[1]      = 1'b1;
    inv_inum_i[13:7] = 7'h31;
    tick();
    clear_inputs();
    set_rd(2, 7'd40);
    #1;
    n_vec++;
    if (lfs_o[20:14] !== 7'h31 || lfs_vld_o[2] !== 1'b0 || vld_cnt_o !== 8'd0) begin
      n_err++;
      $display("FAIL inv_alone got lfs=%h vld=%b cnt=%0d exp lfs=31 vld=0 cnt=0",
               lfs_o[20:14], lfs_vld_o[2], vld_cnt_o);
    end
  endtask

  task automatic test_fill_flush();
    for (int c = 0; c < 32; c++) begin
      clear_inputs();
      for (int k = 0; k < 4; k++) begin
        set_wr(k, 7'(c*4 + k), 7'(c*4 + k));
      end
      tick();
    end
    clear_inputs();
    set_rd(0, 7'd127);
    set_rd(1, 7'd0);
    #1;
    n_vec++;
    if (vld_cnt_o !== 8'd128) begin
      n_err++;
      $display("FAIL fill_cnt got=%0d exp=128", vld_cnt_o);
    end
    n_vec++;
    if (lfs_o[6:0] !== 7'h7F || lfs_o[13:7] !== 7'h00 || lfs_vld_o[1:0] !== 2'b11) begin
      n_err++;
      $display("FAIL fill_read got lfs0=%h lfs1=%h vld=%b exp lfs0=7f lfs1=00 vld=11",
               lfs_o[6:0], lfs_o[13:7], lfs_vld_o[1:0]);
    end
    clear_inputs();
    flush_i = 1'b1;
    set_wr(0, 7'd5, 7'h55);
    tick();
    clear_inputs();
    set_rd(0, 7'd5);
    #1;
    n_vec++;
    if (vld_cnt_o !== 8'd0 || lfs_vld_o[0] !== 1'b0 || lfs_o[6:0] !== 7'h05) begin
      n_err++;
      $display("FAIL flush_drops_write got cnt=%0d vld=%b lfs=%h exp cnt=0 vld=0 lfs=05",
               vld_cnt_o, lfs_vld_o[0], lfs_o[6:0]);
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    set_wr(0, 7'd7, 7'h17);
    tick();
    clear_inputs();
    n_vec++;
    if (vld_cnt_o !== 8'd1) begin
      n_err++;
      $display("FAIL async_setup_cnt got=%0d exp=1", vld_cnt_o);
    end
    #2;
    reset_n = 1'b0;
    set_rd(0, 7'd7);
    #1;
    n_vec++;
    if (vld_cnt_o !== 8'd0 || lfs_vld_o[0] !== 1'b0 || lfs_o[6:0] !== 7'h00) begin
      n_err++;
      $display("FAIL async_reset got cnt=%0d vld=%b lfs=%h exp cnt=0 vld=0 lfs=00",
               vld_cnt_o, lfs_vld_o[0], lfs_o[6:0]);
    end
    tick();
    reset_n = 1'b1;
    tick();
    n_vec++;
    if (lfs_vld_o[0] !== 1'b0 || vld_cnt_o !== 8'd0) begin
      n_err++;
      $display("FAIL after_async_reset got vld=%b cnt=%0d exp vld=0 cnt=0", lfs_vld_o[0], vld_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bundle();
    test_squash();
    test_inv_write();
    test_fill_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
